// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU share arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
// Contents: state_t FSM encoding, default operand/opcode widths, ALU opcodes.
package alu_arb_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_OP_W   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Round-robin winner search: first set valid bit at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; it only reports the winner.
// Ports: valid (request vector), ptr (search start), winner (one-hot),
//        winner_idx (binary index of winner), found (any valid bit set).
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     winner,
   output logic [PTR_W-1:0] winner_idx,
   output logic             found
);

   logic [PTR_W-1:0] j;

   always_comb begin
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      j          = '0;
      for (int k = 0; k < N; k++) begin
         j = PTR_W'((int'(ptr) + k) % N);
         if (!found && valid[j]) begin
            found      = 1'b1;
            winner[j]  = 1'b1;
            winner_idx = j;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters, round-robin granted.
// Latency: accept at cycle t -> one-cycle rsp_valid at t+ALU_LAT+2.
// Backpressure: req_ready is one-hot only in IDLE; responses cannot be stalled.
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_a/req_b/req_op
//        packed per requester; rsp_valid one-hot + shared rsp_data; alu_a/
//        alu_b/alu_opcode to the ALU, alu_c back; busy in EXEC or RESP.
//        Define ALU_ARB_STATS_EN to add grant_cnt (8-bit saturating per requester).
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int OP_W    = DEF_OP_W,
   parameter int ALU_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*OP_W-1:0]   req_op,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W:0]           rsp_data,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [OP_W-1:0]           alu_opcode,
   input  logic [DATA_W:0]           alu_c,
`ifdef ALU_ARB_STATS_EN
   output logic [NUM_REQ*8-1:0]      grant_cnt,
`endif
   output logic                      busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(ALU_LAT + 1);

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [NUM_REQ-1:0] grant;
   logic [CNT_W-1:0]   cnt;

   logic [NUM_REQ-1:0] win;
   logic [PTR_W-1:0]   win_idx;
   logic               found;
   logic [DATA_W-1:0]  sel_a;
   logic [DATA_W-1:0]  sel_b;
   logic [OP_W-1:0]    sel_op;

   rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .valid      (req_valid),
      .ptr        (ptr),
      .winner     (win),
      .winner_idx (win_idx),
      .found      (found)
   );

   // Operand mux driven by the one-hot winner.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) begin
            sel_a  = req_a[i*DATA_W +: DATA_W];
            sel_b  = req_b[i*DATA_W +: DATA_W];
            sel_op = req_op[i*OP_W +: OP_W];
         end
      end
   end

   assign req_ready = (state == IDLE) ? win : '0;
   assign rsp_valid = (state == RESP) ? grant : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         grant      <= '0;
         cnt        <= '0;
         rsp_data   <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  alu_a      <= sel_a;
                  alu_b      <= sel_b;
                  alu_opcode <= sel_op;
                  grant      <= win;
                  ptr        <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                  // Counts ALU_LAT..0, giving ALU_LAT+1 EXEC cycles.
                  cnt        <= CNT_W'(ALU_LAT);
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  rsp_data <= alu_c;
                  state    <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && req_valid[i] && grant_cnt[i*8 +: 8] != 8'hFF) begin
               grant_cnt[i*8 +: 8] <= grant_cnt[i*8 +: 8] + 8'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors, a cycle-level scoreboard
// model and hand-computed literal expectations. Registered ALU model drives alu_c.
// Define ALU_ARB_STATS_EN to also exercise grant_cnt.
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   localparam int N   = 4;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [N*4-1:0] req_a = '0;
   logic [N*4-1:0] req_b = '0;
   logic [N*2-1:0] req_op = '0;
   logic [N-1:0]  rsp_valid;
   logic [4:0]    rsp_data;
   logic [3:0]    alu_a, alu_b;
   logic [1:0]    alu_opcode;
   logic [4:0]    alu_c = '0;
   logic          busy;
`ifdef ALU_ARB_STATS_EN
   logic [N*8-1:0] grant_cnt;
`endif

   alu_share_arbiter #(.NUM_REQ(N), .DATA_W(4), .OP_W(2), .ALU_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_c      (alu_c),
`ifdef ALU_ARB_STATS_EN
      .grant_cnt  (grant_cnt),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      case (op)
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         OP_AND:  return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   // Registered ALU with one cycle of latency.
   always @(posedge clk) alu_c <= alu_fn(alu_a, alu_b, alu_opcode);

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard model ----------------
   // An accepted operation occupies the next LAT+2 cycles; its response
   // appears in the last of them. Winner = first valid at/after ptr, wrapping.
   int          m_ptr = 0;
   int          m_left = 0;
   int          m_req = 0;
   logic [4:0]  m_res = '0;
   logic [4:0]  m_data = '0;
   logic [9:0]  m_in = '0;
   int          w;
   logic [N-1:0] e_rdy, e_rsp;
   logic        e_busy;
   int          gnt_cyc[$], gnt_idx[$], rsp_cyc[$], rsp_vec[$];

   always @(negedge clk) begin
      if (chk_en) begin
         w = -1;
         e_rdy = '0;
         e_rsp = '0;
         if (m_left == 0) begin
            e_busy = 1'b0;
            for (int k = 0; k < N; k++)
               if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) e_rdy = N'(1) << w;
         end else begin
            e_busy = 1'b1;
            if (m_left == 1) begin
               e_rsp  = N'(1) << m_req;
               m_data = m_res;
            end
         end
         chk("req_ready", 32'(req_ready), 32'(e_rdy));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("rsp_data", 32'(rsp_data), 32'(m_data));
         if (m_left >= 2) chk("alu_in", 32'({alu_a, alu_b, alu_opcode}), 32'(m_in));
         if (req_ready != '0) begin gnt_cyc.push_back(cyc); gnt_idx.push_back(w); end
         if (rsp_valid != '0) begin rsp_cyc.push_back(cyc); rsp_vec.push_back(int'(rsp_valid)); end
         if (rst) begin
            m_left = 0; m_ptr = 0; m_data = '0;
         end else if (m_left == 0 && w >= 0) begin
            m_left = LAT + 2;
            m_req  = w;
            m_in   = {req_a[w*4 +: 4], req_b[w*4 +: 4], req_op[w*2 +: 2]};
            m_res  = alu_fn(req_a[w*4 +: 4], req_b[w*4 +: 4], req_op[w*2 +: 2]);
            m_ptr  = (w + 1) % N;
         end else if (m_left > 0) begin
            m_left--;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      req_a[i*4 +: 4]  = a;
      req_b[i*4 +: 4]  = b;
      req_op[i*2 +: 2] = op;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (req_ready != '0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL wait_ready timeout actual=no_ready required=ready");
      end
   endtask

   task automatic single(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic [4:0] exp_d);
      bit ok;
      @(posedge clk); #1;
      set_req(i, a, b, op);
      req_valid = N'(1) << i;
      wait_ready(ok);
      if (ok) begin
         chk("single_grant", 32'(req_ready), 32'(N'(1) << i));
         @(posedge clk); #1;
         req_valid = '0;
         @(negedge clk);
         chk("single_busy_t1", 32'(busy), 32'd1);
         chk("single_rsp_t1", 32'(rsp_valid), 32'd0);
         @(negedge clk);
         chk("single_busy_t2", 32'(busy), 32'd1);
         @(negedge clk);
         chk("single_rsp_t3", 32'(rsp_valid), 32'(N'(1) << i));
         chk("single_data_t3", 32'(rsp_data), 32'(exp_d));
         @(negedge clk);
         chk("single_idle_t4", 32'({busy, rsp_valid}), 32'd0);
      end else begin
         req_valid = '0;
      end
   endtask

   int exp_g[5] = '{0, 1, 2, 3, 0};

   initial begin
      bit ok;
      int n, g0, r0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_rsp", 32'(rsp_valid), 32'd0);
      chk("reset_data", 32'(rsp_data), 32'd0);
      chk("reset_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);

      // All four held valid: grants 0,1,2,3,0, four cycles apart.
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 4'(i), OP_ADD);
      g0 = gnt_idx.size();
      r0 = rsp_vec.size();
      n = 0;
      req_valid = '1;
      for (int k = 0; k < 60 && n < 5; k++) begin
         @(negedge clk);
         if (req_ready != '0) n++;
      end
      @(posedge clk); #1;
      req_valid = '0;
      repeat (6) @(posedge clk);
      #1;
      chk("rr_grant_count", 32'(gnt_idx.size() - g0), 32'd5);
      chk("rr_rsp_count", 32'(rsp_vec.size() - r0), 32'd5);
      if (gnt_idx.size() >= g0 + 5 && rsp_vec.size() >= r0 + 5) begin
         for (int k = 0; k < 5; k++) begin
            chk("rr_order", 32'(gnt_idx[g0 + k]), 32'(exp_g[k]));
            chk("rr_rsp_vec", 32'(rsp_vec[r0 + k]), 32'(1 << exp_g[k]));
            chk("rr_rsp_lat", 32'(rsp_cyc[r0 + k] - gnt_cyc[g0 + k]), 32'd3);
            if (k > 0) chk("rr_rsp_spacing", 32'(rsp_cyc[r0 + k] - rsp_cyc[r0 + k - 1]), 32'd4);
         end
      end

      // Single requesters, ptr starts at 1 here.
      single(0, 4'd2,  4'd1,  OP_ADD, 5'd3);
      single(1, 4'd15, 4'd10, OP_ADD, 5'd25);
      single(3, 4'd5,  4'd7,  OP_SUB, 5'd30);
      single(0, 4'd12, 4'd10, OP_AND, 5'd8);
      single(2, 4'd5,  4'd10, OP_OR,  5'd15);
      // ptr is 3: requester 2 alone is found by wrapping; ptr stays 3.
      single(2, 4'd9,  4'd9,  OP_ADD, 5'd18);

      // 2 and 3 both valid with ptr=3: 3 must win.
      @(posedge clk); #1;
      set_req(3, 4'd6, 4'd3, OP_SUB);
      req_valid = 4'b1100;
      wait_ready(ok);
      chk("ptr_after_wrap", 32'(req_ready), 32'h8);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (4) @(negedge clk);

      // Reset during the second EXEC cycle drops the operation.
      @(posedge clk); #1;
      set_req(2, 4'd1, 4'd1, OP_ADD);
      req_valid = 4'b0100;
      wait_ready(ok);
      @(posedge clk); #1;
      req_valid = '0;
      n = rsp_vec.size();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", 32'(req_ready), 32'd0);
      chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_mid_data", 32'(rsp_data), 32'd0);
      chk("rst_mid_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_no_rsp", 32'(rsp_vec.size()), 32'(n));
      set_req(1, 4'd3, 4'd4, OP_ADD);
      set_req(3, 4'd3, 4'd4, OP_ADD);
      req_valid = 4'b1010;
      wait_ready(ok);
      chk("grant_after_rst", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (4) @(negedge clk);
      chk("data_after_rst", 32'(rsp_data), 32'd7);

`ifdef ALU_ARB_STATS_EN
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("stats_reset", 32'(grant_cnt), 32'd0);
      set_req(0, 4'd1, 4'd1, OP_ADD);
      req_valid = 4'b0001;
      n = 0;
      for (int k = 0; k < 1400 && n < 300; k++) begin
         @(negedge clk);
         if (req_ready[0]) n++;
      end
      @(posedge clk); #1;
      req_valid = '0;
      chk("stats_grants", 32'(n), 32'd300);
      repeat (5) @(negedge clk);
      chk("stats_cnt0", 32'(grant_cnt[7:0]), 32'd255);
      chk("stats_others", 32'(grant_cnt[N*8-1:8]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("stats_cleared", 32'(grant_cnt), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
